// File: rtl/approx_rec_mult_pipe.sv
// Pipelined unsigned WIDTHxWIDTH recursive multiplier built from 4x4 sub-products.
// Low-significance sub-products can be swapped for the OR-compressed approximate cell.
module approx_rec_mult_pipe #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned APPROX_DEPTH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 approx_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   y,
   output logic                 y_approx,
   output logic [15:0]          beat_count
);

   localparam int unsigned N  = WIDTH / 4;
   localparam int unsigned NP = N * N;
   localparam int unsigned YW = 2 * WIDTH;

   // Approximate 4x4 cell: column-wise OR of partial products, top two columns re-encoded
   function automatic logic [7:0] approx_cell(input logic [3:0] p, input logic [3:0] q);
      logic [7:0] c;
      c[0] = p[0] & q[0];
      c[1] = (p[0] & q[1]) | (p[1] & q[0]);
      c[2] = (p[0] & q[2]) | (p[1] & q[1]) | (p[2] & q[0]);
      c[3] = (p[0] & q[3]) | (p[1] & q[2]) | (p[2] & q[1]) | (p[3] & q[0]);
      c[4] = (p[1] & q[3]) | (p[2] & q[2]) | (p[3] & q[1]);
      c[5] = (p[2] & q[3]) | (p[3] & q[2]);
      c[6] = p[3] & q[3] & ~(p[2] & q[2]);
      c[7] = p[3] & q[3] & p[2] & q[2];
      return c;
   endfunction

   logic              adv;
   logic              v1;
   logic              v2;
   logic              ap1;
   logic              ap2;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [8*NP-1:0]   pp_d;
   logic [8*NP-1:0]   pp_q;
   logic [YW-1:0]     sum_d;

   // Whole pipeline advances together unless the output beat is stalled
   always_comb begin
      adv      = ~out_valid | out_ready;
      in_ready = adv & ~rst;
   end

   // Stage 2 sub-products, sub-product (i,j) stored at slot i*N+j
   always_comb begin
      pp_d = '0;
      for (int unsigned i = 0; i < N; i++) begin
         for (int unsigned j = 0; j < N; j++) begin
            if (ap1 && ((i + j) < APPROX_DEPTH))
               pp_d[8*(i*N+j) +: 8] = approx_cell(a_q[4*i +: 4], b_q[4*j +: 4]);
            else
               pp_d[8*(i*N+j) +: 8] = 8'(a_q[4*i +: 4]) * 8'(b_q[4*j +: 4]);
         end
      end
   end

   // Stage 3 shift-add tree
   always_comb begin
      sum_d = '0;
      for (int unsigned i = 0; i < N; i++) begin
         for (int unsigned j = 0; j < N; j++) begin
            sum_d = sum_d + (YW'(pp_q[8*(i*N+j) +: 8]) << (4*(i+j)));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1         <= 1'b0;
         v2         <= 1'b0;
         ap1        <= 1'b0;
         ap2        <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         pp_q       <= '0;
         out_valid  <= 1'b0;
         y          <= '0;
         y_approx   <= 1'b0;
         beat_count <= '0;
      end else begin
         if (out_valid && out_ready)
            beat_count <= beat_count + 16'd1;
         if (adv) begin
            v1 <= in_valid;
            if (in_valid) begin
               a_q <= a;
               b_q <= b;
               ap1 <= approx_en;
            end
            v2 <= v1;
            if (v1) begin
               pp_q <= pp_d;
               ap2  <= ap1;
            end
            out_valid <= v2;
            if (v2) begin
               y        <= sum_d;
               y_approx <= ap2 & (APPROX_DEPTH != 0);
            end
         end
      end
   end

endmodule

// File: tb/tb_approx_rec_mult_pipe.sv
// Directed and randomised self-checking bench for approx_rec_mult_pipe.
// Three instances share stimulus: 8-bit depth 1, 8-bit depth 0, 16-bit depth 3.
module tb_approx_rec_mult_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        ap_in;
   logic [15:0] a_in;
   logic [15:0] b_in;

   logic        in_ready8, out_valid8, ya8;
   logic [15:0] y8, bc8;
   logic        in_ready8z, out_valid8z, ya8z;
   logic [15:0] y8z, bc8z;
   logic        in_ready16, out_valid16, ya16;
   logic [31:0] y16;
   logic [15:0] bc16;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] e8;
      logic [15:0] e8z;
      logic [31:0] e16;
      logic        ap;
   } exp_t;

   approx_rec_mult_pipe #(.WIDTH(8), .APPROX_DEPTH(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
      .a(a_in[7:0]), .b(b_in[7:0]), .approx_en(ap_in), .out_valid(out_valid8),
      .out_ready(out_ready), .y(y8), .y_approx(ya8), .beat_count(bc8));

   approx_rec_mult_pipe #(.WIDTH(8), .APPROX_DEPTH(0)) dut8z (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8z),
      .a(a_in[7:0]), .b(b_in[7:0]), .approx_en(ap_in), .out_valid(out_valid8z),
      .out_ready(out_ready), .y(y8z), .y_approx(ya8z), .beat_count(bc8z));

   approx_rec_mult_pipe #(.WIDTH(16), .APPROX_DEPTH(3)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
      .a(a_in), .b(b_in), .approx_en(ap_in), .out_valid(out_valid16),
      .out_ready(out_ready), .y(y16), .y_approx(ya16), .beat_count(bc16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic logic [7:0] tb_cell(input logic [3:0] p, input logic [3:0] q);
      logic [7:0] c;
      c = '0;
      for (int m = 0; m < 4; m++)
         for (int n = 0; n < 4; n++)
            if (p[m] && q[n] && (m + n) <= 5) c[m+n] = 1'b1;
      c[6] = p[3] & q[3] & ~(p[2] & q[2]);
      c[7] = p[3] & q[3] & p[2] & q[2];
      return c;
   endfunction

   // Exact product corrected by the difference of every approximated sub-product
   function automatic logic [31:0] model(input logic [15:0] av, input logic [15:0] bv,
                                         input logic ap, input int w, input int depth);
      logic [31:0] r;
      logic [3:0]  p;
      logic [3:0]  q;
      r = 32'(av) * 32'(bv);
      for (int i = 0; i < w/4; i++)
         for (int j = 0; j < w/4; j++)
            if (ap && (i + j) < depth) begin
               p = av[4*i +: 4];
               q = bv[4*j +: 4];
               r = r - ((32'(p) * 32'(q)) << (4*(i+j))) + (32'(tb_cell(p, q)) << (4*(i+j)));
            end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends one beat into an empty pipeline and waits for its result
   task automatic run_beat(input logic [15:0] ai, input logic [15:0] bi, input logic ap,
                           output logic [15:0] ry8, output logic rya8,
                           output logic [15:0] ry8z, output logic rya8z, output int lat);
      a_in = ai; b_in = bi; ap_in = ap; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid8 !== 1'b1 && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (out_valid8 !== 1'b1) lat = -1;
      ry8 = y8; rya8 = ya8; ry8z = y8z; rya8z = ya8z;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ap_in = 1'b0; a_in = '0; b_in = '0;
      step();
      checks++;
      if (in_ready8 !== 1'b0) begin failures++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready8); end
      step();
      rst = 1'b0;
      step();
      checks++;
      if (out_valid8 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid8); end
      checks++;
      if (y8 !== 16'h0 || ya8 !== 1'b0) begin failures++; $display("FAIL reset_y got=%h/%b exp=0/0", y8, ya8); end
      checks++;
      if (bc8 !== 16'h0) begin failures++; $display("FAIL reset_beat_count got=%0d exp=0", bc8); end
      checks++;
      if (in_ready8 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready8); end
   endtask

   task automatic test_mode_compare();
      logic [15:0] ry, ryz;
      logic        rya, ryaz;
      int          lat;
      run_beat(16'h0F, 16'h0F, 1'b0, ry, rya, ryz, ryaz, lat);
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL mode_exact_latency got=%0d exp=3", lat); end
      checks++;
      if (ry !== 16'h00E1 || rya !== 1'b0) begin failures++; $display("FAIL mode_exact got=%h/%b exp=00e1/0", ry, rya); end
      run_beat(16'h0F, 16'h0F, 1'b1, ry, rya, ryz, ryaz, lat);
      checks++;
      if (ry !== 16'h00BF || rya !== 1'b1) begin failures++; $display("FAIL mode_approx got=%h/%b exp=00bf/1", ry, rya); end
      checks++;
      if (ryz !== 16'h00E1 || ryaz !== 1'b0) begin failures++; $display("FAIL mode_depth0 got=%h/%b exp=00e1/0", ryz, ryaz); end
   endtask

   task automatic test_full_range();
      logic [15:0] ry, ryz;
      logic        rya, ryaz;
      int          lat;
      run_beat(16'hFF, 16'hFF, 1'b1, ry, rya, ryz, ryaz, lat);
      checks++;
      if (ry !== 16'hFDDF) begin failures++; $display("FAIL full_approx got=%h exp=fddf", ry); end
      run_beat(16'hFF, 16'hFF, 1'b0, ry, rya, ryz, ryaz, lat);
      checks++;
      if (ry !== 16'hFE01) begin failures++; $display("FAIL full_exact got=%h exp=fe01", ry); end
   endtask

   task automatic test_small();
      logic [15:0] ry, ryz;
      logic        rya, ryaz;
      int          lat;
      run_beat(16'h3, 16'h3, 1'b1, ry, rya, ryz, ryaz, lat);
      checks++;
      if (ry !== 16'd7 || rya !== 1'b1) begin failures++; $display("FAIL small_approx got=%0d/%b exp=7/1", ry, rya); end
      checks++;
      if (ryz !== 16'd9 || ryaz !== 1'b0) begin failures++; $display("FAIL small_depth0 got=%0d/%b exp=9/0", ryz, ryaz); end
   endtask

   task automatic test_back_pressure();
      logic [15:0] exp_bp [5] = '{16'd2, 16'd6, 16'd12, 16'd20, 16'd30};
      logic [15:0] got [5];
      int          k = 1, nout = 0, held = 0;
      logic        seen = 1'b0, acc;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int cyc = 0; cyc < 40 && nout < 5; cyc++) begin
         out_ready = !(seen && held < 4);
         in_valid  = (k <= 5);
         a_in = 16'(k); b_in = 16'(k + 1); ap_in = 1'b0;
         #1;
         if (out_valid8 && !out_ready) begin
            held++;
            checks++;
            if (in_ready8 !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready8); end
            checks++;
            if (y8 !== 16'd2) begin failures++; $display("FAIL bp_y_stable got=%0d exp=2", y8); end
         end
         acc = in_valid & in_ready8;
         if (out_valid8 && out_ready && nout < 5) begin
            got[nout] = y8;
            nout++;
         end
         @(posedge clk);
         #1;
         if (acc) k++;
         if (out_valid8) seen = 1'b1;
      end
      in_valid = 1'b0;
      checks++;
      if (nout !== 5 || held !== 4) begin failures++; $display("FAIL bp_counts got=%0d/%0d exp=5/4", nout, held); end
      for (int i = 0; i < nout; i++) begin
         checks++;
         if (got[i] !== exp_bp[i]) begin failures++; $display("FAIL bp_out%0d got=%0d exp=%0d", i, got[i], exp_bp[i]); end
      end
      checks++;
      if (bc8 !== 16'd5) begin failures++; $display("FAIL bp_beat_count got=%0d exp=5", bc8); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] ry, ryz;
      logic        rya, ryaz, seen;
      int          lat;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a_in = 16'(i + 10); b_in = 16'(i + 20); ap_in = 1'b0;
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (out_valid8 !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid8); end
      checks++;
      if (bc8 !== 16'd0) begin failures++; $display("FAIL mid_beat_count got=%0d exp=0", bc8); end
      out_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (out_valid8) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin failures++; $display("FAIL mid_discard got=%b exp=0", seen); end
      run_beat(16'd7, 16'd9, 1'b0, ry, rya, ryz, ryaz, lat);
      checks++;
      if (lat !== 3 || ry !== 16'd63) begin failures++; $display("FAIL mid_next_beat got=%0d/%0d exp=3/63", lat, ry); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [4] = '{16'h0F, 16'h0F, 16'hFF, 16'h03};
      logic        vap [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [15:0] ey [4] = '{16'h00BF, 16'h00E1, 16'hFDDF, 16'h0009};
      logic [15:0] gy [4];
      logic        gya [4];
      logic        acc;
      int          k = 0, nout = 0, ncyc = 0;
      out_ready = 1'b1;
      while (ncyc < 20 && nout < 4) begin
         in_valid = (k < 4);
         a_in = va[k % 4]; b_in = va[k % 4]; ap_in = vap[k % 4];
         #1;
         acc = in_valid & in_ready8;
         if (out_valid8) begin
            gy[nout] = y8; gya[nout] = ya8;
            nout++;
         end
         @(posedge clk);
         #1;
         if (acc) k++;
         ncyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (nout !== 4 || ncyc !== 7) begin failures++; $display("FAIL b2b_throughput got=%0d/%0d exp=4/7", nout, ncyc); end
      for (int i = 0; i < nout; i++) begin
         checks++;
         if (gy[i] !== ey[i] || gya[i] !== vap[i])
            begin failures++; $display("FAIL b2b_out%0d got=%h/%b exp=%h/%b", i, gy[i], gya[i], ey[i], vap[i]); end
      end
   endtask

   task automatic test_random();
      exp_t sb[$];
      exp_t e;
      int   sent = 0;
      logic acc;
      for (int cyc = 0; cyc < 3000 && (sent < 60 || sb.size() != 0); cyc++) begin
         in_valid  = (sent < 60) && ($urandom_range(0, 1) == 1);
         a_in      = 16'($urandom);
         b_in      = 16'($urandom);
         ap_in     = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         acc = in_valid & in_ready8;
         if (acc) begin
            e.e8  = 16'(model({8'h0, a_in[7:0]}, {8'h0, b_in[7:0]}, ap_in, 8, 1));
            e.e8z = 16'(model({8'h0, a_in[7:0]}, {8'h0, b_in[7:0]}, 1'b0, 8, 0));
            e.e16 = model(a_in, b_in, ap_in, 16, 3);
            e.ap  = ap_in;
            sb.push_back(e);
            sent++;
         end
         if (out_valid8 && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++; $display("FAIL rand_unexpected got=%h exp=none", y8);
            end else begin
               e = sb.pop_front();
               if (y8 !== e.e8 || ya8 !== e.ap)
                  begin failures++; $display("FAIL rand_w8 got=%h/%b exp=%h/%b", y8, ya8, e.e8, e.ap); end
               checks++;
               if (out_valid16 !== 1'b1 || y16 !== e.e16 || ya16 !== e.ap)
                  begin failures++; $display("FAIL rand_w16 got=%h/%b exp=%h/%b", y16, ya16, e.e16, e.ap); end
               checks++;
               if (y8z !== e.e8z || ya8z !== 1'b0)
                  begin failures++; $display("FAIL rand_depth0 got=%h/%b exp=%h/0", y8z, ya8z, e.e8z); end
            end
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      checks++;
      if (sent !== 60 || sb.size() !== 0)
         begin failures++; $display("FAIL rand_drain got=%0d/%0d exp=60/0", sent, sb.size()); end
   endtask

   initial begin
      test_reset();
      test_mode_compare();
      test_full_range();
      test_small();
      test_back_pressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
